// File: rtl/stream_pkg.sv
// Shared stream definitions: default word width, level-width helper and word type.
package stream_pkg;

    localparam int STREAM_DATA_WIDTH = 8;

    typedef logic [STREAM_DATA_WIDTH-1:0] stream_word_t;

    // Occupancy counters must represent 0..depth inclusive, so one extra bit.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/stream_source_fifo_if.sv
// Write-side and sink-side handshake bundle for stream_source_fifo.
//
// Handshake: a word moves on a rising clk edge where valid && ready are both
// high. A producer holds valid and data stable until that edge, and ready is
// never derived from valid. wr_* is the producer-to-FIFO side; stream_in_* is
// the FIFO-to-sink side.
interface stream_source_fifo_if
    import stream_pkg::*;
#(
    parameter int DATA_WIDTH = STREAM_DATA_WIDTH
);
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  stream_in_valid;
    logic                  stream_in_ready;
    logic [DATA_WIDTH-1:0] stream_in_data;

    // Driver/sink side: pushes words and accepts the head word.
    modport master (
        output wr_valid, wr_data, stream_in_ready,
        input  wr_ready, stream_in_valid, stream_in_data
    );

    // FIFO side.
    modport slave (
        input  wr_valid, wr_data, stream_in_ready,
        output wr_ready, stream_in_valid, stream_in_data
    );
endinterface

// File: rtl/stream_fifo_mem.sv
// DEPTH x DATA_WIDTH flop storage: one synchronous write port, one
// asynchronous read port. Contents are deliberately not reset.
module stream_fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write the addressed entry when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/stream_source_fifo.sv
// First-word-fall-through byte FIFO feeding the stream sink stage.
// Optional macro STREAM_SOURCE_FIFO_HIGH_WATER_EN adds a high_water output
// holding the peak occupancy since reset or flush.
module stream_source_fifo
    import stream_pkg::*;
#(
    parameter int  DATA_WIDTH = STREAM_DATA_WIDTH,
    parameter int  DEPTH      = 8,
    localparam int LEVEL_W    = level_width(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    stream_source_fifo_if.slave bus,
    output logic [LEVEL_W-1:0] level
`ifdef STREAM_SOURCE_FIFO_HIGH_WATER_EN
    ,
    output logic [LEVEL_W-1:0] high_water
`endif
);
    localparam int AW = LEVEL_W - 1;

    // Pointers carry a wrap bit above the address bits so full and empty
    // are distinguishable when the address bits match.
    logic [LEVEL_W-1:0] wr_ptr;
    logic [LEVEL_W-1:0] rd_ptr;
    logic [LEVEL_W-1:0] level_nxt;
    logic               empty;
    logic               full;
    logic               push;
    logic               pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign bus.wr_ready        = !full;
    assign bus.stream_in_valid = !empty;

    // Flush wins over both transfers in the same cycle.
    assign push = bus.wr_valid && !full && !flush;
    assign pop  = bus.stream_in_valid && bus.stream_in_ready && !flush;

    stream_fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) u_mem (
        .clk  (clk),
        .we   (push),
        .waddr(wr_ptr[AW-1:0]),
        .wdata(bus.wr_data),
        .raddr(rd_ptr[AW-1:0]),
        .rdata(bus.stream_in_data)
    );

    // Advance pointers on accepted transfers; flush returns them to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + LEVEL_W'(1);
            if (pop)  rd_ptr <= rd_ptr + LEVEL_W'(1);
        end
    end

    // Next occupancy: up on push only, down on pop only, else hold.
    always_comb begin
        level_nxt = level;
        if (flush) begin
            level_nxt = '0;
        end else if (push && !pop) begin
            level_nxt = level + LEVEL_W'(1);
        end else if (pop && !push) begin
            level_nxt = level - LEVEL_W'(1);
        end
    end

    // Registered occupancy, kept equal to wr_ptr - rd_ptr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= '0;
        end else begin
            level <= level_nxt;
        end
    end

`ifdef STREAM_SOURCE_FIFO_HIGH_WATER_EN
    // Track peak occupancy; cleared by reset and flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            high_water <= '0;
        end else if (flush) begin
            high_water <= '0;
        end else if (level_nxt > high_water) begin
            high_water <= level_nxt;
        end
    end
`endif
endmodule

// File: tb/tb_stream_source_fifo.sv
// Self-checking bench for stream_source_fifo with a queue-based reference.
module tb_stream_source_fifo;
    import stream_pkg::*;

    localparam int DEPTH   = 8;
    localparam int LEVEL_W = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic [LEVEL_W-1:0] level;
`ifdef STREAM_SOURCE_FIFO_HIGH_WATER_EN
    logic [LEVEL_W-1:0] high_water;
`endif

    always #5 clk = ~clk;

    stream_source_fifo_if #(.DATA_WIDTH(8)) sif ();

    stream_source_fifo #(
        .DATA_WIDTH(8),
        .DEPTH     (DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .flush(flush),
        .bus  (sif),
        .level(level)
`ifdef STREAM_SOURCE_FIFO_HIGH_WATER_EN
        ,
        .high_water(high_water)
`endif
    );

    // ---------------- reference model / scoreboard ----------------
    logic [7:0] exp_q[$];
    int         hw_model = 0;
    int         n_cmp = 0;
    int         n_err = 0;

    // Drive one cycle from a negedge, update the model at the posedge,
    // and return at the next negedge where outputs are sampled.
    task automatic step(input logic wv, input logic [7:0] wd, input logic rdy, input logic fl);
        bit do_push;
        bit do_pop;
        sif.wr_valid        = wv;
        sif.wr_data         = wd;
        sif.stream_in_ready = rdy;
        flush               = fl;
        do_push = wv && (exp_q.size() < DEPTH) && !fl;
        do_pop  = rdy && (exp_q.size() > 0) && !fl;
        @(posedge clk);
        if (fl) begin
            exp_q.delete();
            hw_model = 0;
        end else begin
            if (do_pop)  void'(exp_q.pop_front());
            if (do_push) exp_q.push_back(wd);
            if (exp_q.size() > hw_model) hw_model = exp_q.size();
        end
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        sif.wr_valid = 1'b0; sif.wr_data = '0; sif.stream_in_ready = 1'b0; flush = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({sif.stream_in_valid, sif.wr_ready, level} !== {1'b0, 1'b1, 4'd0}) begin
            n_err++;
            $display("FAIL reset_state: got valid=%b ready=%b level=%0d want 0 1 0",
                     sif.stream_in_valid, sif.wr_ready, level);
        end
        rst_n = 1'b1;
        exp_q.delete();
        hw_model = 0;
        idle();
    endtask

    task automatic test_basic_push();
        step(1'b1, 8'h11, 1'b0, 1'b0);
        n_cmp++;
        if (sif.stream_in_valid !== 1'b1 || sif.stream_in_data !== 8'h11) begin
            n_err++;
            $display("FAIL push_latency: got valid=%b data=%h want 1 11",
                     sif.stream_in_valid, sif.stream_in_data);
        end
        step(1'b1, 8'h22, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b0);
        idle();
        n_cmp++;
        if ({level, sif.stream_in_valid, sif.stream_in_data, sif.wr_ready} !== {4'd3, 1'b1, 8'h11, 1'b1}) begin
            n_err++;
            $display("FAIL basic_three: got level=%0d valid=%b data=%h ready=%b want 3 1 11 1",
                     level, sif.stream_in_valid, sif.stream_in_data, sif.wr_ready);
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (sif.stream_in_data !== exp_q[0]) begin
                n_err++;
                $display("FAIL basic_drain[%0d]: got %h want %h", i, sif.stream_in_data, exp_q[0]);
            end
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        n_cmp++;
        if (sif.stream_in_valid !== 1'b0 || level !== 4'd0) begin
            n_err++;
            $display("FAIL basic_empty: got valid=%b level=%0d want 0 0", sif.stream_in_valid, level);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 8; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
        n_cmp++;
        if (level !== 4'd8 || sif.wr_ready !== 1'b0) begin
            n_err++;
            $display("FAIL full_flags: got level=%0d ready=%b want 8 0", level, sif.wr_ready);
        end
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        n_cmp++;
        if (level !== 4'd8) begin
            n_err++;
            $display("FAIL full_ninth: got level=%0d want 8", level);
        end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (sif.stream_in_valid !== 1'b1 || sif.stream_in_data !== 8'hA0 + 8'(i)) begin
                n_err++;
                $display("FAIL full_drain[%0d]: got valid=%b data=%h want 1 %h",
                         i, sif.stream_in_valid, sif.stream_in_data, 8'hA0 + 8'(i));
            end
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        n_cmp++;
        if (sif.stream_in_valid !== 1'b0 || sif.wr_ready !== 1'b1) begin
            n_err++;
            $display("FAIL full_after_drain: got valid=%b ready=%b want 0 1", sif.stream_in_valid, sif.wr_ready);
        end
    endtask

    task automatic test_full_pop_push();
        for (int i = 0; i < 8; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'hBB, 1'b1, 1'b0);
        n_cmp++;
        if (sif.wr_ready !== 1'b1 || level !== 4'd7) begin
            n_err++;
            $display("FAIL full_pop_ready: got ready=%b level=%0d want 1 7", sif.wr_ready, level);
        end
        step(1'b1, 8'hBB, 1'b0, 1'b0);
        n_cmp++;
        if (level !== 4'd8 || sif.wr_ready !== 1'b0) begin
            n_err++;
            $display("FAIL full_refill: got level=%0d ready=%b want 8 0", level, sif.wr_ready);
        end
        while (exp_q.size() > 0) begin
            n_cmp++;
            if (sif.stream_in_data !== exp_q[0]) begin
                n_err++;
                $display("FAIL refill_order: got %h want %h", sif.stream_in_data, exp_q[0]);
            end
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] d;
        d = 8'h40;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, d, 1'b0, 1'b0);
            d++;
        end
        for (int i = 0; i < 20; i++) begin
            n_cmp++;
            if (sif.stream_in_data !== exp_q[0] || level !== 4'd4) begin
                n_err++;
                $display("FAIL wrap[%0d]: got data=%h level=%0d want %h 4", i, sif.stream_in_data, level, exp_q[0]);
            end
            step(1'b1, d, 1'b1, 1'b0);
            d++;
        end
        while (exp_q.size() > 0) begin
            n_cmp++;
            if (sif.stream_in_data !== exp_q[0]) begin
                n_err++;
                $display("FAIL wrap_drain: got %h want %h", sif.stream_in_data, exp_q[0]);
            end
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) step(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b1, 1'b1);
        n_cmp++;
        if ({level, sif.stream_in_valid, sif.wr_ready} !== {4'd0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL flush_state: got level=%0d valid=%b ready=%b want 0 0 1",
                     level, sif.stream_in_valid, sif.wr_ready);
        end
`ifdef STREAM_SOURCE_FIFO_HIGH_WATER_EN
        n_cmp++;
        if (high_water !== 4'd0) begin
            n_err++;
            $display("FAIL flush_high_water: got %0d want 0", high_water);
        end
`endif
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        n_cmp++;
        if (level !== 4'd1 || sif.stream_in_data !== 8'h5A) begin
            n_err++;
            $display("FAIL flush_next_push: got level=%0d data=%h want 1 5a", level, sif.stream_in_data);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0);
        sif.wr_valid = 1'b1; sif.wr_data = 8'h99; sif.stream_in_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({level, sif.stream_in_valid, sif.wr_ready} !== {4'd0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL async_reset: got level=%0d valid=%b ready=%b want 0 0 1",
                     level, sif.stream_in_valid, sif.wr_ready);
        end
        exp_q.delete();
        hw_model = 0;
        @(negedge clk);
        sif.wr_valid = 1'b0; sif.stream_in_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        step(1'b1, 8'h77, 1'b0, 1'b0);
        n_cmp++;
        if (sif.stream_in_valid !== 1'b1 || sif.stream_in_data !== 8'h77 || level !== 4'd1) begin
            n_err++;
            $display("FAIL post_reset_push: got valid=%b data=%h level=%0d want 1 77 1",
                     sif.stream_in_valid, sif.stream_in_data, level);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 29) == 0));
            n_cmp++;
            if ({sif.stream_in_valid, sif.wr_ready, level} !==
                {exp_q.size() != 0, exp_q.size() < DEPTH, 4'(exp_q.size())}) begin
                n_err++;
                $display("FAIL rand_state[%0d]: got valid=%b ready=%b level=%0d want level=%0d",
                         i, sif.stream_in_valid, sif.wr_ready, level, exp_q.size());
            end
            if (exp_q.size() > 0) begin
                n_cmp++;
                if (sif.stream_in_data !== exp_q[0]) begin
                    n_err++;
                    $display("FAIL rand_data[%0d]: got %h want %h", i, sif.stream_in_data, exp_q[0]);
                end
            end
`ifdef STREAM_SOURCE_FIFO_HIGH_WATER_EN
            n_cmp++;
            if (high_water !== 4'(hw_model)) begin
                n_err++;
                $display("FAIL rand_high_water[%0d]: got %0d want %0d", i, high_water, hw_model);
            end
`endif
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        @(negedge clk);
        test_reset();
        test_basic_push();
        test_full();
        test_full_pop_push();
        test_wrap();
        test_flush();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
